bcd_six_to_bin: RTL

- Sequential six-digit BCD to 20-bit binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD nibble >= 8.
- Inverse of the binary-to-BCD display path. Feeds entered or received decimal values back into binary counters and comparators.
- One iteration per clock; start/busy/done handshake.

---
 rtl/bcd_six_to_bin.sv | 105 ++++++++++
 1 files changed

// File: rtl/bcd_six_to_bin.sv
// ============================================================================
// Module   : bcd_six_to_bin
// Purpose  : Six-digit BCD to 20-bit binary converter (reverse double-dabble)
// Options  : BCD_DIGIT_CHK_EN - flag digits above 9 and force data to zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_six_to_bin (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [3:0]  unit,
  input  logic [3:0]  ten,
  input  logic [3:0]  hun,
  input  logic [3:0]  tho,
  input  logic [3:0]  t_tho,
  input  logic [3:0]  h_hun,
  output logic [19:0] data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_CONV   = 1'b1;
  localparam logic [4:0] C_LAST   = 5'd19;
  localparam int         C_NIBS   = 6;

  logic [0:0]  r_state;
  logic [4:0]  r_cnt;
  logic [43:0] r_wr;
  logic        r_err_cap;
  logic [19:0] r_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [43:0] w_shift;
  logic [43:0] w_next;
  logic        w_dig_err;

  assign w_shift        = {1'b0, r_wr[43:1]};
  assign w_next[19:0]   = w_shift[19:0];

  // Each BCD nibble is corrected independently; no borrow between digits.
  generate
    for (genvar g = 0; g < C_NIBS; g++) begin : g_nib
      assign w_next[20+4*g +: 4] = (w_shift[20+4*g +: 4] >= 4'd8) ?
                                   (w_shift[20+4*g +: 4] - 4'd3) :
                                    w_shift[20+4*g +: 4];
    end
  endgenerate

`ifdef BCD_DIGIT_CHK_EN
  assign w_dig_err = (unit  > 4'd9) | (ten   > 4'd9) | (hun   > 4'd9) |
                     (tho   > 4'd9) | (t_tho > 4'd9) | (h_hun > 4'd9);
`else
  assign w_dig_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_wr      <= 44'd0;
      r_err_cap <= 1'b0;
      r_data    <= 20'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_wr      <= {h_hun, t_tho, tho, hun, ten, unit, 20'd0};
          r_cnt     <= 5'd0;
          r_busy    <= 1'b1;
          r_err_cap <= w_dig_err;
          r_state   <= S_CONV;
        end
      end else begin
        r_wr <= w_next;
        if (r_cnt == C_LAST) begin
          r_data  <= r_err_cap ? 20'd0 : w_next[19:0];
          r_done  <= 1'b1;
          r_err   <= r_err_cap;
          r_busy  <= 1'b0;
          r_cnt   <= 5'd0;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  assign data = r_data;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

`default_nettype wire
